univ_reg: RTL

UNIV_REG -- requirements
Module: univ_reg

---
 rtl/univ_reg.sv | 106 ++++++++++
 1 files changed

// File: rtl/univ_reg.sv
// Universal register: parallel load, logical/arithmetic shifts, rotates and
// increment/decrement, with a registered carry/borrow/shifted-out bit and a
// combinational zero flag. Every operation reads the pre-edge register
// contents and completes in one clock.
module univ_reg #(
  parameter int WIDTH     = 8,
  parameter int ARITH_SHR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] In,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Out,
  output logic             carry_out,
  output logic             zero
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_INC  = 3'b110;
  localparam logic [2:0] M_DEC  = 3'b111;

  // One in the low bit, zero-extended to the width of the carry-extended sums.
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             shr_fill;

  // Increment/decrement with an extra MSB so the wrap shows up as carry/borrow.
  always_comb begin
    sum_ext  = {1'b0, out_q} + ONE_EXT;
    diff_ext = {1'b0, out_q} - ONE_EXT;
    shr_fill = (ARITH_SHR != 0) ? out_q[WIDTH-1] : ser_in;
  end

  // Next-state decode; enable low (or hold) leaves both registers unchanged.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    if (enable) begin
      case (mode)
        M_HOLD: begin
          out_d   = out_q;
          carry_d = carry_q;
        end
        M_LOAD: begin
          out_d   = In;
          carry_d = 1'b0;
        end
        M_SHL: begin
          out_d   = {out_q[WIDTH-2:0], ser_in};
          carry_d = out_q[WIDTH-1];
        end
        M_SHR: begin
          out_d   = {shr_fill, out_q[WIDTH-1:1]};
          carry_d = out_q[0];
        end
        M_ROL: begin
          out_d   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          carry_d = out_q[WIDTH-1];
        end
        M_ROR: begin
          out_d   = {out_q[0], out_q[WIDTH-1:1]};
          carry_d = out_q[0];
        end
        M_INC: begin
          out_d   = sum_ext[WIDTH-1:0];
          carry_d = sum_ext[WIDTH];
        end
        M_DEC: begin
          out_d   = diff_ext[WIDTH-1:0];
          carry_d = diff_ext[WIDTH];
        end
        default: begin
          out_d   = out_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  // State register; reset wins over any operation on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign Out       = out_q;
  assign carry_out = carry_q;
  assign zero      = (out_q == '0);

endmodule
